// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : uart_rx_ctrl_if
// Description : Signal bundle between the UART RX sequencer and its
//               neighbours (line, edge/bit counter, data sampler, consumer).
//               slave  : the sequencer (uart_rx_ctrl)
//               master : the surrounding receive path that feeds it
//               Line/config : rx_in, prescale, par_en, par_typ
//               Counter     : edge_cnt, bit_cnt (in), en_counter, cnt_clear (out)
//               Sampler     : sampled_bit (in), dat_samp_en (out)
//               Result      : p_data, data_valid, par_err, stp_err, strt_glitch
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx_in;
    logic [4:0]            prescale;
    logic                  par_en;
    logic                  par_typ;
    logic [4:0]            edge_cnt;
    logic [3:0]            bit_cnt;
    logic                  sampled_bit;
    logic                  en_counter;
    logic                  cnt_clear;
    logic                  dat_samp_en;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  strt_glitch;

    modport slave (
        input  rx_in, prescale, par_en, par_typ, edge_cnt, bit_cnt, sampled_bit,
        output en_counter, cnt_clear, dat_samp_en, p_data,
               data_valid, par_err, stp_err, strt_glitch
    );

    modport master (
        output rx_in, prescale, par_en, par_typ, edge_cnt, bit_cnt, sampled_bit,
        input  en_counter, cnt_clear, dat_samp_en, p_data,
               data_valid, par_err, stp_err, strt_glitch
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : uart_rx_ctrl
// Description : UART receive sequencer. Walks start/data/parity/stop bits of
//               each frame using the external edge/bit counter and the
//               majority-voted sample, deserialises LSB-first, checks parity
//               and stop, and reports the result with one-cycle pulses.
// Ports       : clk, rst (sync, active high)
//               bus (uart_rx_ctrl_if.slave) - line, config, counter and
//               sampler handshakes plus p_data and status pulses
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    uart_rx_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [3:0] C_LAST_DATA = 4'(DATA_WIDTH);
    localparam logic [3:0] C_PAR_IDX   = 4'(DATA_WIDTH + 1);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_par_ok;
    logic                  r_data_valid;
    logic                  r_par_err;
    logic                  r_stp_err;
    logic                  r_strt_glitch;
    logic                  r_cnt_clear;

    logic [4:0]            w_sp_edge;
    logic                  w_sp;
    logic                  w_in_data;
    logic [3:0]            w_stop_idx;
    logic                  w_par_exp;

    // Sample point: first edge at which the sampler's 3-sample vote is valid.
    assign w_sp_edge  = (bus.prescale >> 1) + 5'd2;
    assign w_sp       = (bus.edge_cnt == w_sp_edge);
    assign w_in_data  = (bus.bit_cnt >= 4'd1) && (bus.bit_cnt <= C_LAST_DATA);
    assign w_stop_idx = C_PAR_IDX + {3'b000, bus.par_en};
    assign w_par_exp  = (^r_shreg) ^ bus.par_typ;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_shreg       <= '0;
            r_p_data      <= '0;
            r_par_ok      <= 1'b0;
            r_data_valid  <= 1'b0;
            r_par_err     <= 1'b0;
            r_stp_err     <= 1'b0;
            r_strt_glitch <= 1'b0;
            r_cnt_clear   <= 1'b0;
        end else begin
            // Status and clear are single-cycle pulses by default.
            r_data_valid  <= 1'b0;
            r_par_err     <= 1'b0;
            r_stp_err     <= 1'b0;
            r_strt_glitch <= 1'b0;
            r_cnt_clear   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!bus.rx_in) begin
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (w_sp) begin
                        r_cnt_clear <= 1'b1;
                        r_state     <= S_IDLE;
                        if (bus.bit_cnt == 4'd0) begin
                            if (bus.sampled_bit) begin
                                r_strt_glitch <= 1'b1;
                            end else begin
                                r_cnt_clear <= 1'b0;
                                r_par_ok    <= 1'b0;
                                r_state     <= S_DATA;
                            end
                        end
                    end
                end

                S_DATA: begin
                    if (w_sp) begin
                        if (w_in_data) begin
                            r_shreg <= {bus.sampled_bit, r_shreg[DATA_WIDTH-1:1]};
                            if (bus.bit_cnt == C_LAST_DATA) begin
                                r_state <= bus.par_en ? S_PARITY : S_STOP;
                            end
                        end else begin
                            // Counter and sequencer disagree: drop silently.
                            r_cnt_clear <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end
                end

                S_PARITY: begin
                    if (w_sp) begin
                        if (bus.bit_cnt != C_PAR_IDX) begin
                            r_cnt_clear <= 1'b1;
                            r_state     <= S_IDLE;
                        end else if (bus.sampled_bit != w_par_exp) begin
                            r_par_err   <= 1'b1;
                            r_cnt_clear <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_par_ok <= 1'b1;
                            r_state  <= S_STOP;
                        end
                    end
                end

                S_STOP: begin
                    if (w_sp) begin
                        r_cnt_clear <= 1'b1;
                        r_state     <= S_IDLE;
                        if (bus.bit_cnt == w_stop_idx) begin
                            if (!bus.sampled_bit) begin
                                r_stp_err <= 1'b1;
                            end else if (r_par_ok || !bus.par_en) begin
                                r_p_data     <= r_shreg;
                                r_data_valid <= 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.en_counter  = (r_state != S_IDLE);
    assign bus.dat_samp_en = (r_state != S_IDLE);
    assign bus.cnt_clear   = r_cnt_clear;
    assign bus.p_data      = r_p_data;
    assign bus.data_valid  = r_data_valid;
    assign bus.par_err     = r_par_err;
    assign bus.stp_err     = r_stp_err;
    assign bus.strt_glitch = r_strt_glitch;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : tb_uart_rx_ctrl
// Description : Bench for uart_rx_ctrl. Models the edge/bit counter and the
//               3-sample majority sampler around the sequencer, drives serial
//               frames and scores status events against a queue of expected
//               events pushed when each frame is driven.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    typedef struct packed {
        logic [3:0] pulses;   // {strt_glitch, stp_err, par_err, data_valid}
        logic [7:0] data;
        logic [3:0] bitc;
        logic [4:0] edgec;
        logic       clr;
        logic       en;
    } ev_t;

    logic clk;
    logic rst;

    uart_rx_ctrl_if #(.DATA_WIDTH(8)) bus ();

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ev_t        exp_q[$];
    ev_t        obs_q[$];
    int         n_checks;
    int         n_fail;
    logic [7:0] model_pdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge/bit counter model: free-runs while enabled, cleared otherwise.
    always @(posedge clk) begin
        if (rst || bus.cnt_clear || !bus.en_counter) begin
            bus.edge_cnt <= 5'd0;
            bus.bit_cnt  <= 4'd0;
        end else if (bus.edge_cnt == bus.prescale - 5'd1) begin
            bus.edge_cnt <= 5'd0;
            bus.bit_cnt  <= bus.bit_cnt + 4'd1;
        end else begin
            bus.edge_cnt <= bus.edge_cnt + 5'd1;
        end
    end

    // Majority sampler model: samples around mid-bit, vote visible at SP.
    logic [1:0] samp;
    always @(posedge clk) begin
        if (rst || !bus.dat_samp_en) begin
            samp            <= 2'b00;
            bus.sampled_bit <= 1'b1;
        end else begin
            if (bus.edge_cnt == (bus.prescale >> 1) - 5'd1) samp[0] <= bus.rx_in;
            if (bus.edge_cnt == (bus.prescale >> 1))        samp[1] <= bus.rx_in;
            if (bus.edge_cnt == (bus.prescale >> 1) + 5'd1)
                bus.sampled_bit <= (samp[0] & samp[1]) | (samp[0] & bus.rx_in) | (samp[1] & bus.rx_in);
        end
    end

    // Event monitor: every cycle with any status pulse becomes one event.
    always @(negedge clk) begin
        if (!rst && ({bus.strt_glitch, bus.stp_err, bus.par_err, bus.data_valid} != 4'b0000)) begin
            obs_q.push_back('{pulses: {bus.strt_glitch, bus.stp_err, bus.par_err, bus.data_valid},
                              data: bus.p_data, bitc: bus.bit_cnt, edgec: bus.edge_cnt,
                              clr: bus.cnt_clear, en: bus.en_counter});
        end
    end

    function automatic ev_t mk_ev(input logic [3:0] pulses, input logic [7:0] data,
                                  input logic [3:0] bitc, input int presc);
        ev_t e;
        e.pulses = pulses;
        e.data   = data;
        e.bitc   = bitc;
        e.edgec  = 5'(presc / 2 + 3);   // one edge past the sample point
        e.clr    = 1'b1;
        e.en     = 1'b0;
        return e;
    endfunction

    function automatic string ev_str(input ev_t e);
        return $sformatf("pulses=%b p_data=%h bit=%0d edge=%0d clr=%b en=%b",
                         e.pulses, e.data, e.bitc, e.edgec, e.clr, e.en);
    endfunction

    task automatic cfg(input logic [4:0] presc, input logic pe, input logic pt);
        bus.prescale = presc;
        bus.par_en   = pe;
        bus.par_typ  = pt;
    endtask

    task automatic line_bit(input logic b);
        bus.rx_in = b;
        repeat (int'(bus.prescale)) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par_bit, input logic stop_bit);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(data[i]);
        if (bus.par_en) line_bit(par_bit);
        line_bit(stop_bit);
        bus.rx_in = 1'b1;
    endtask

    // Wait (bounded) for the expected number of events, then a few more cycles
    // so stray extra events are also caught.
    task automatic settle();
        for (int i = 0; i < 64 && obs_q.size() < exp_q.size(); i++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.rx_in = 1'b1;
        cfg(5'd8, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.en_counter, bus.dat_samp_en, bus.cnt_clear, bus.data_valid, bus.par_err,
             bus.stp_err, bus.strt_glitch, bus.p_data} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%b samp=%b clr=%b dv=%b pe=%b se=%b sg=%b p_data=%h, expected all 0",
                     bus.en_counter, bus.dat_samp_en, bus.cnt_clear, bus.data_valid, bus.par_err,
                     bus.stp_err, bus.strt_glitch, bus.p_data);
        end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.en_counter, bus.cnt_clear} !== 2'b00 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_idle: got en=%b clr=%b events=%0d, expected en=0 clr=0 events=0",
                     bus.en_counter, bus.cnt_clear, obs_q.size());
        end
        model_pdata = 8'h00;
    endtask

    task automatic test_basic_p8();
        ev_t e, o;
        cfg(5'd8, 1'b0, 1'b0);
        model_pdata = 8'hA5;
        exp_q.push_back(mk_ev(4'b0001, model_pdata, 4'd9, 8));
        send_frame(8'hA5, 1'b0, 1'b1);
        settle();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL basic_event: got %s, expected %s", ev_str(o), ev_str(e));
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_parity_p16();
        ev_t e, o;
        cfg(5'd16, 1'b1, 1'b0);
        // 0x3C has four ones: even parity bit 0 is good, 1 is bad.
        model_pdata = 8'h3C;
        exp_q.push_back(mk_ev(4'b0001, model_pdata, 4'd10, 16));
        send_frame(8'h3C, 1'b0, 1'b1);
        exp_q.push_back(mk_ev(4'b0010, model_pdata, 4'd9, 16));
        send_frame(8'h3C, 1'b1, 1'b1);
        settle();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL parity_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL parity_event: got %s, expected %s", ev_str(o), ev_str(e));
            end
        end
        exp_q.delete();
        obs_q.delete();
        n_checks++;
        if (bus.p_data !== model_pdata) begin
            n_fail++;
            $display("FAIL parity_hold: got p_data=%h, expected %h", bus.p_data, model_pdata);
        end
    endtask

    task automatic test_start_glitch();
        ev_t e, o;
        cfg(5'd8, 1'b0, 1'b0);
        exp_q.push_back(mk_ev(4'b1000, model_pdata, 4'd0, 8));
        bus.rx_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.rx_in = 1'b1;
        settle();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL glitch_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL glitch_event: got %s, expected %s", ev_str(o), ev_str(e));
            end
        end
        exp_q.delete();
        obs_q.delete();
        n_checks++;
        if ({bus.en_counter, bus.edge_cnt, bus.bit_cnt} !== 10'd0) begin
            n_fail++;
            $display("FAIL glitch_idle: got en=%b edge=%0d bit=%0d, expected en=0 edge=0 bit=0",
                     bus.en_counter, bus.edge_cnt, bus.bit_cnt);
        end
    endtask

    task automatic test_stop_error();
        ev_t e, o;
        cfg(5'd8, 1'b0, 1'b0);
        exp_q.push_back(mk_ev(4'b0100, model_pdata, 4'd9, 8));
        send_frame(8'h0F, 1'b0, 1'b0);
        settle();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL stop_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL stop_event: got %s, expected %s", ev_str(o), ev_str(e));
            end
        end
        exp_q.delete();
        obs_q.delete();
        n_checks++;
        if (bus.en_counter !== 1'b0 || bus.p_data !== model_pdata) begin
            n_fail++;
            $display("FAIL stop_idle: got en=%b p_data=%h, expected en=0 p_data=%h",
                     bus.en_counter, bus.p_data, model_pdata);
        end
    endtask

    task automatic test_back_to_back();
        ev_t e, o;
        cfg(5'd8, 1'b0, 1'b0);
        exp_q.push_back(mk_ev(4'b0001, 8'h55, 4'd9, 8));
        exp_q.push_back(mk_ev(4'b0001, 8'hAA, 4'd9, 8));
        model_pdata = 8'hAA;
        send_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b1);
        settle();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b_event: got %s, expected %s", ev_str(o), ev_str(e));
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_midframe();
        ev_t e, o;
        logic [7:0] part;
        int         waited;
        cfg(5'd8, 1'b0, 1'b0);
        part = 8'hFF;
        line_bit(1'b0);
        for (int i = 0; i < 3; i++) line_bit(part[i]);
        bus.rx_in = part[3];
        waited = 0;
        while (bus.bit_cnt != 4'd4 && waited < 32) begin
            @(posedge clk);
            #1;
            waited++;
        end
        n_checks++;
        if (bus.bit_cnt !== 4'd4 || bus.en_counter !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_reach: got bit=%0d en=%b, expected bit=4 en=1", bus.bit_cnt, bus.en_counter);
        end
        rst       = 1'b1;
        bus.rx_in = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.en_counter, bus.dat_samp_en, bus.cnt_clear, bus.data_valid, bus.par_err,
             bus.stp_err, bus.strt_glitch, bus.p_data} !== 15'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got en=%b samp=%b clr=%b dv=%b pe=%b se=%b sg=%b p_data=%h, expected all 0",
                     bus.en_counter, bus.dat_samp_en, bus.cnt_clear, bus.data_valid, bus.par_err,
                     bus.stp_err, bus.strt_glitch, bus.p_data);
        end
        rst = 1'b0;
        model_pdata = 8'h00;
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (obs_q.size() != 0 || bus.en_counter !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_quiet: got events=%0d en=%b, expected events=0 en=0", obs_q.size(), bus.en_counter);
        end
        obs_q.delete();
        model_pdata = 8'h81;
        exp_q.push_back(mk_ev(4'b0001, model_pdata, 4'd9, 8));
        send_frame(8'h81, 1'b0, 1'b1);
        settle();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL midrst_event: got %s, expected %s", ev_str(o), ev_str(e));
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        model_pdata = 8'h00;
        rst         = 1'b1;
        bus.rx_in   = 1'b1;
        cfg(5'd8, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        test_reset();
        test_basic_p8();
        test_parity_p16();
        test_start_glitch();
        test_stop_error();
        test_back_to_back();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side sequencer for the UART RX path.
- Tracks start, data, optional parity and stop bits of each frame from the edge/bit counter values and the majority-voted sample.
- Drives the counter enable/clear and the sampler enable; deserialises data LSB-first, checks parity and stop, and presents the parallel byte with a one-cycle valid pulse.
- Sits between rx_in, edge_bit_counter and data_sampling inside UART_Rx.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame; supported values 5..8.

Ports:
- clk  input  1  receiver oversampling clock
- rst  input  1  synchronous, active-high reset
- rx_in  input  1  serial line, idle high
- prescale  input  5  oversampling ratio; legal values 8 or 16
- par_en  input  1  1 = frame carries a parity bit
- par_typ  input  1  0 = even parity, 1 = odd parity
- edge_cnt  input  5  edge count within current bit, from edge_bit_counter
- bit_cnt  input  4  bit index within frame (0 = start), from edge_bit_counter
- sampled_bit  input  1  majority-voted bit value from data_sampling
- en_counter  output  1  enable to edge_bit_counter
- cnt_clear  output  1  clear to edge_bit_counter (drives its data_valid clear input)
- dat_samp_en  output  1  enable to data_sampling
- p_data  output  DATA_WIDTH  last good received byte
- data_valid  output  1  one-cycle pulse: p_data updated
- par_err  output  1  one-cycle pulse: parity mismatch, frame dropped
- stp_err  output  1  one-cycle pulse: stop bit sampled 0, frame dropped
- strt_glitch  output  1  one-cycle pulse: start bit not confirmed

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE.
  - p_data, shift register, data_valid, par_err, stp_err, strt_glitch, cnt_clear all 0.
  - Reset mid-frame abandons the frame with no pulses.
- Sample point: SP = (edge_cnt == prescale[4:1] + 2), using 5-bit compare. This gives 6 for prescale 8 and 10 for prescale 16, the first edge at which sampled_bit reflects the 3-sample vote.
- en_counter = dat_samp_en = (state != IDLE), decoded combinationally from state.
- States and transitions:
  - IDLE: rx_in==0 -> START. Otherwise stay.
  - START: at SP with bit_cnt==0:
    - sampled_bit==0 -> DATA.
    - sampled_bit==1 -> IDLE, with strt_glitch and cnt_clear pulsed.
  - DATA: at SP with bit_cnt in 1..DATA_WIDTH, shift sampled_bit in LSB-first (shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]}). At SP with bit_cnt==DATA_WIDTH, after the shift -> PARITY if par_en, else STOP.
  - PARITY: at SP with bit_cnt==DATA_WIDTH+1:
    - Expected bit = ^shreg XOR par_typ.
    - Mismatch -> IDLE, with par_err and cnt_clear pulsed.
    - Match -> STOP, with the match recorded.
  - STOP: at SP with bit_cnt==DATA_WIDTH+1+par_en:
    - sampled_bit==1 -> IDLE, with p_data<=shreg, data_valid and cnt_clear pulsed.
    - sampled_bit==0 -> IDLE, with stp_err and cnt_clear pulsed; p_data unchanged.
- Timing of status pulses:
  - data_valid, par_err, stp_err, strt_glitch and cnt_clear are registered.
  - They are high for exactly the one cycle following the deciding SP edge, the first cycle in IDLE.
  - At most one of data_valid/par_err/stp_err/strt_glitch is high in any cycle.
- SP with mismatched bit_cnt (counter/state disagreement) -> IDLE with cnt_clear pulsed and no status pulse.
- Back-to-back frames: the FSM leaves STOP at mid-stop-bit. If rx_in==0 in the cnt_clear cycle, IDLE -> START on the next edge; the counter is cleared on that same edge, so the new frame starts at edge_cnt=0.
- Configuration inputs (prescale, par_en, par_typ) must be stable while state != IDLE. Changes mid-frame are undefined.
- p_data holds its value until the next good frame.

Test Plan:
- prescale=8, par_en=0, frame 0xA5 with good stop -> p_data=8'hA5; data_valid one cycle 1 clk after SP of stop bit (bit_cnt=9, edge_cnt=6); no error pulses.
- prescale=16, par_en=1, par_typ=0, byte 0x3C with parity bit 0 -> data_valid, p_data=8'h3C. Same byte with parity bit 1 -> par_err pulse, no data_valid, p_data keeps 8'h3C.
- prescale=8, rx_in low for 3 clk then high -> strt_glitch pulse at SP of bit 0; return to IDLE; en_counter 0; counter cleared.
- prescale=8, frame 0x0F with stop bit 0 -> stp_err pulse, cnt_clear pulse, p_data unchanged, FSM in IDLE.
- Two frames 0x55 then 0xAA with no idle gap beyond one stop bit -> two data_valid pulses, p_data=8'h55 then 8'hAA.
- rst=1 asserted during DATA (bit_cnt=4) -> next cycle state IDLE, all outputs 0; a subsequent clean frame 0x81 is received correctly.
